fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and BOOT/RUN/HALT control.
// Optional macro MISALIGN_CHECK_EN turns misaligned redirect targets into a sticky fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_n,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_INST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INST,
  output logic        IFID_VALID,
  output logic        HALTED,
  output logic [15:0] FETCH_CNT,
  output logic        MISALIGN
);

  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_HALT = 2'd2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;
  logic        load_bubble, load_fetch;
  logic        bad_target;

`ifdef MISALIGN_CHECK_EN
  assign bad_target = (REDIRECT_PC[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;

    if (state_q == ST_BOOT) begin
      load_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (REDIRECT) begin
      load_bubble = 1'b1;
      if (bad_target) begin
        misalign_d = 1'b1;
        state_d    = ST_HALT;
      end else begin
        pc_d    = REDIRECT_PC & 32'hFFFF_FFFC;
        state_d = ST_RUN;
      end
    end else if (state_q != ST_RUN) begin
      load_bubble = 1'b1;
    end else if (STALL) begin
      load_bubble = FLUSH;
    end else if (FLUSH) begin
      load_bubble = 1'b1;
      pc_d        = pc_q + 32'd4;
    end else if (IMEM_INST == 32'h0000_0000) begin
      // An all-zero word marks the end of the program image.
      load_bubble = 1'b1;
      state_d     = ST_HALT;
    end else begin
      load_fetch = 1'b1;
      pc_d       = pc_q + 32'd4;
    end

    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    if (load_bubble) begin
      ifid_inst_d  = NOP;
      ifid_valid_d = 1'b0;
    end else if (load_fetch) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_q + 32'd4;
      ifid_inst_d  = IMEM_INST;
      ifid_valid_d = 1'b1;
      if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_inst_q  <= NOP;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= 16'h0;
      misalign_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

  assign IMEM_ADDR  = pc_q;
  assign IFID_PC    = ifid_pc_q;
  assign IFID_PC4   = ifid_pc4_q;
  assign IFID_INST  = ifid_inst_q;
  assign IFID_VALID = ifid_valid_q;
  assign HALTED     = (state_q == ST_HALT);
  assign FETCH_CNT  = fetch_cnt_q;
  assign MISALIGN   = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a rule-level model predicts the post-edge outputs,
// a monitor compares them every clock; directed scenarios add constant checks.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [31:0] IMEM_ADDR, IMEM_INST;
  logic        STALL, FLUSH, REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] IFID_PC, IFID_PC4, IFID_INST;
  logic        IFID_VALID, HALTED, MISALIGN;
  logic [15:0] FETCH_CNT;

  logic [31:0] mem [256];
  assign IMEM_INST = mem[IMEM_ADDR[9:2]];

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST_n(RST_n), .IMEM_ADDR(IMEM_ADDR), .IMEM_INST(IMEM_INST),
    .STALL(STALL), .FLUSH(FLUSH), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IFID_PC(IFID_PC), .IFID_PC4(IFID_PC4), .IFID_INST(IFID_INST),
    .IFID_VALID(IFID_VALID), .HALTED(HALTED), .FETCH_CNT(FETCH_CNT), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr, pc, pc4, inst;
    logic        valid, halted, mis;
    logic [15:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_inst;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;
  int          m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ipc = 0; m_ipc4 = 0; m_inst = 32'h13;
    m_valid = 0; m_mis = 0; m_cnt = 0; m_st = S_BOOT;
  endtask

  task automatic model_step(input bit r, input logic [31:0] rpc, input bit s, input bit f);
    logic [31:0] word;
    bit bub, take;
    snap_t e;
    word = mem[m_pc[9:2]];
    bub = 0; take = 0;
    if (m_st == S_BOOT) begin
      bub = 1; m_st = S_RUN;
    end else if (r) begin
      bub = 1;
      if (MIS_EN && rpc[1:0] != 2'b00) begin m_mis = 1; m_st = S_HALT; end
      else begin m_pc = {rpc[31:2], 2'b00}; m_st = S_RUN; end
    end else if (m_st == S_HALT) bub = 1;
    else if (s) bub = f;
    else if (f) begin bub = 1; m_pc = m_pc + 4; end
    else if (word == 0) begin bub = 1; m_st = S_HALT; end
    else take = 1;
    if (bub) begin m_inst = 32'h13; m_valid = 0; end
    if (take) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = word; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
    e = '{addr: m_pc, pc: m_ipc, pc4: m_ipc4, inst: m_inst, valid: m_valid,
          halted: (m_st == S_HALT), mis: m_mis, cnt: m_cnt};
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus and predict the outputs after the next edge.
  task automatic cyc(input bit r, input logic [31:0] rpc, input bit s, input bit f);
    @(negedge CLK);
    RST_n = 1; REDIRECT = r; REDIRECT_PC = rpc; STALL = s; FLUSH = f;
    model_step(r, rpc, s, f);
  endtask

  task automatic after_edge();
    @(posedge CLK); #2;
  endtask

  task automatic reset_checks();
    check("rst_addr",  IMEM_ADDR, RESET_PC);
    check("rst_inst",  IFID_INST, 32'h13);
    check("rst_valid", IFID_VALID, 0);
    check("rst_pc",    IFID_PC, 0);
    check("rst_pc4",   IFID_PC4, 0);
    check("rst_halt",  HALTED, 0);
    check("rst_cnt",   FETCH_CNT, 0);
    check("rst_mis",   MISALIGN, 0);
  endtask

  always @(posedge CLK) begin
    if (RST_n === 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underrun: got no expectation, required one (t=%0t)", $time);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        check("sb_addr",   IMEM_ADDR, e.addr);
        check("sb_pc",     IFID_PC, e.pc);
        check("sb_pc4",    IFID_PC4, e.pc4);
        check("sb_inst",   IFID_INST, e.inst);
        check("sb_valid",  IFID_VALID, e.valid);
        check("sb_halted", HALTED, e.halted);
        check("sb_mis",    MISALIGN, e.mis);
        check("sb_cnt",    FETCH_CNT, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] save_pc;
    logic [15:0] save_cnt;
    RST_n = 0; STALL = 0; FLUSH = 0; REDIRECT = 0; REDIRECT_PC = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
    mem[0] = 32'hff81_0113; mem[1] = 32'h0141_2223;
    mem[5] = 32'h0000_0513; mem[32] = 32'h0;
    model_reset();
    #12;
    reset_checks();

    // Reset release and the first two fetches
    cyc(0, 0, 0, 0); after_edge();
    check("boot_valid", IFID_VALID, 0);
    check("boot_inst",  IFID_INST, 32'h13);
    cyc(0, 0, 0, 0); after_edge();
    check("e2_pc",   IFID_PC, 0);
    check("e2_inst", IFID_INST, 32'hff81_0113);
    cyc(0, 0, 0, 0); after_edge();
    check("e3_pc",   IFID_PC, 4);
    check("e3_inst", IFID_INST, 32'h0141_2223);
    check("e3_cnt",  FETCH_CNT, 2);

    // Redirect from PC=100 to 20
    for (int i = 0; i < 100 && m_pc != 100; i++) cyc(0, 0, 0, 0);
    cyc(1, 20, 0, 0); after_edge();
    check("redir_addr",  IMEM_ADDR, 20);
    check("redir_valid", IFID_VALID, 0);
    cyc(0, 0, 0, 0); after_edge();
    check("redir_pc",   IFID_PC, 20);
    check("redir_inst", IFID_INST, 32'h0000_0513);

    // Stall at PC=32, then stall+flush
    for (int i = 0; i < 100 && m_pc != 32; i++) cyc(0, 0, 0, 0);
    save_pc = m_ipc; save_cnt = m_cnt;
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); after_edge();
    check("stall_addr", IMEM_ADDR, 32);
    check("stall_pc",   IFID_PC, save_pc);
    check("stall_cnt",  FETCH_CNT, save_cnt);
    cyc(0, 0, 1, 1); after_edge();
    check("sf_addr",  IMEM_ADDR, 32);
    check("sf_valid", IFID_VALID, 0);
    check("sf_inst",  IFID_INST, 32'h13);

    // Halt on zero word at PC=128, then redirect out
    for (int i = 0; i < 100 && m_st != S_HALT; i++) cyc(0, 0, 0, 0);
    after_edge();
    check("halt_flag", HALTED, 1);
    check("halt_addr", IMEM_ADDR, 128);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    after_edge();
    check("halt_valid", IFID_VALID, 0);
    check("halt_hold",  IMEM_ADDR, 128);
    cyc(1, 0, 0, 0); after_edge();
    check("unhalt_flag", HALTED, 0);
    check("unhalt_addr", IMEM_ADDR, 0);

    // Misaligned redirect target 22
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 22, 0, 0); after_edge();
`ifdef MISALIGN_CHECK_EN
    check("mis_flag", MISALIGN, 1);
    check("mis_halt", HALTED, 1);
    check("mis_addr", IMEM_ADDR, 8);
`else
    check("mis_addr", IMEM_ADDR, 20);
    check("mis_flag", MISALIGN, 0);
`endif
    cyc(1, 0, 0, 0);

    // Randomised traffic with a few extra end-of-program words
    for (int i = 0; i < 4; i++) mem[$urandom_range(40, 255)] = 32'h0;
    for (int i = 0; i < 500; i++) begin
      bit r, s, f;
      logic [31:0] t;
      r = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 7) == 0);
      t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom);
      cyc(r, t, s, f);
    end

    // Reset asserted mid-cycle while halted and stalled
    cyc(1, 128, 0, 0);
    for (int i = 0; i < 10 && m_st != S_HALT; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); after_edge();
    check("pre_rst_halt", HALTED, 1);
    @(negedge CLK); #2;
    RST_n = 0;
    #1;
    reset_checks();
    model_reset();
    cyc(0, 0, 0, 0); after_edge();
    check("reboot_valid", IFID_VALID, 0);
    check("reboot_addr",  IMEM_ADDR, RESET_PC);
    check("reboot_cnt",   FETCH_CNT, 0);
    cyc(0, 0, 0, 0); after_edge();
    check("reboot_inst", IFID_INST, 32'hff81_0113);

    @(negedge CLK);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
